// File: rtl/mem_responder.sv
// Slave-side memory responder: request/grant/rvalid protocol, word-addressed storage,
// fixed-latency in-order responses, outstanding cap. Optional: MEM_RESPONDER_GNT_STALL_EN.
module mem_responder #(
   parameter int ADDRESS_SIZE    = 64,
   parameter int DATA_WIDTH      = 64,
   parameter int NUM_WORDS       = 1024,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [ADDRESS_SIZE-1:0]   address,
   input  logic [DATA_WIDTH-1:0]     data_wdata,
   input  logic                      data_req,
   input  logic                      data_we,
   input  logic [DATA_WIDTH/8-1:0]   data_be,
   output logic                      data_gnt,
   output logic                      data_rvalid,
   output logic [DATA_WIDTH-1:0]     data_rdata
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(NB);
   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [CNT_W-1:0]      outstanding;
   logic                  vld_p  [LATENCY];
   logic [DATA_WIDTH-1:0] data_p [LATENCY];
   logic                  stall;
   logic                  gnt;
   logic                  unused_addr;

   // Upper and byte-offset address bits are ignored, so addresses wrap.
   assign idx         = address[OFF +: IDX_W];
   assign rd_word     = mem[idx];
   assign unused_addr = ^address;

`ifdef MEM_RESPONDER_GNT_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign gnt      = data_req & ~rst_i & (outstanding < MAX_CNT) & ~stall;
   assign data_gnt = gnt;

   // Read data is taken combinationally above, so a same-edge write cannot affect it.
   always_ff @(posedge clk_i) begin
      if (gnt && data_we) begin
         for (int i = 0; i < NB; i++) begin
            if (data_be[i]) begin
               mem[idx][8*i +: 8] <= data_wdata[8*i +: 8];
            end
         end
      end
   end

   // Stage 0 captures the granted response; later stages shift it to the output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld_p[i]  <= 1'b0;
            data_p[i] <= '0;
         end
      end else begin
         vld_p[0]  <= gnt;
         data_p[0] <= (gnt && !data_we) ? rd_word : '0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            data_p[i] <= data_p[i-1];
         end
      end
   end

   assign data_rvalid = vld_p[LATENCY-1];
   assign data_rdata  = data_p[LATENCY-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding <= '0;
      end else begin
         case ({gnt, data_rvalid})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed protocol scenarios plus a randomized run checked
// against a transaction-level model (response queue with due cycles, word array).
module tb_mem_responder;

   localparam int LAT  = 2;
   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [63:0] address = '0;
   logic [63:0] data_wdata = '0;
   logic        data_req = 1'b0;
   logic        data_we = 1'b0;
   logic [7:0]  data_be = '0;
   logic        data_gnt;
   logic        data_rvalid;
   logic [63:0] data_rdata;

   mem_responder #(
      .ADDRESS_SIZE(64), .DATA_WIDTH(64), .NUM_WORDS(1024),
      .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .address(address), .data_wdata(data_wdata),
      .data_req(data_req), .data_we(data_we), .data_be(data_be),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [63:0] dat; } resp_t;

   resp_t       pend[$];
   logic [63:0] mem_m [1024];
   logic [15:0] m_lfsr = 16'hACE1;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic        obs_gnt, exp_gnt, obs_rv, exp_rv;
   logic [63:0] obs_rd, exp_rd;

   // One bus cycle: drive after the falling edge, sample, then advance the model past the rising edge.
   task automatic do_cycle(input logic rq, input logic w, input logic [63:0] a,
                           input logic [63:0] wd, input logic [7:0] b, input logic r);
      logic        stall;
      int          idx;
      logic [63:0] word;
      @(negedge clk);
      rst_i = r; data_req = rq; data_we = w; address = a; data_wdata = wd; data_be = b;
      #1;
      obs_gnt = data_gnt; obs_rv = data_rvalid; obs_rd = data_rdata;
`ifdef MEM_RESPONDER_GNT_STALL_EN
      stall = (m_lfsr[1:0] == 2'b00);
`else
      stall = 1'b0;
`endif
      exp_gnt = rq && !r && (pend.size() < MAXO) && !stall;
      exp_rv  = (pend.size() > 0) && (pend[0].due == cyc);
      exp_rd  = exp_rv ? pend[0].dat : 64'h0;
      if (exp_rv) void'(pend.pop_front());
      if (r) begin
         pend.delete();
         m_lfsr = 16'hACE1;
      end else begin
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         if (exp_gnt) begin
            idx  = int'((a >> 3) & 64'h3FF);
            word = mem_m[idx];
            pend.push_back('{due: cyc + LAT, dat: w ? 64'h0 : word});
            if (w) for (int bb = 0; bb < 8; bb++) if (b[bb]) mem_m[idx][8*bb +: 8] = wd[8*bb +: 8];
         end
      end
      cyc++;
   endtask

   task automatic test_reset;
      do_cycle(1'b1, 1'b1, 64'h10, 64'hFFFF, 8'hFF, 1'b1);
      do_cycle(1'b1, 1'b1, 64'h10, 64'hFFFF, 8'hFF, 1'b1);
      n_checks++;
      if (obs_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b expected 0", obs_gnt); end
      do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0);
      n_checks++;
      if (obs_rv !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 0", obs_rv); end
      n_checks++;
      if (obs_rd !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", obs_rd); end
   endtask

   // Issue one request at k=0 then idle; grant expected at k=0, rvalid at k=LAT.
   task automatic single_txn(input string nm, input logic w, input logic [63:0] a,
                             input logic [63:0] wd, input logic [7:0] b, input logic [63:0] rd_req);
      for (int k = 0; k < 4; k++) begin
         do_cycle(k == 0, w, a, wd, b, 1'b0);
         n_checks++;
         if (obs_gnt !== (k == 0)) begin n_fail++; $display("FAIL %s_gnt k=%0d: got %b expected %b", nm, k, obs_gnt, k == 0); end
         n_checks++;
         if (obs_rv !== (k == LAT)) begin n_fail++; $display("FAIL %s_rvalid k=%0d: got %b expected %b", nm, k, obs_rv, k == LAT); end
         if (k == LAT) begin
            n_checks++;
            if (obs_rd !== rd_req) begin n_fail++; $display("FAIL %s_rdata: got %h expected %h", nm, obs_rd, rd_req); end
         end
      end
   endtask

   task automatic test_single_write;
      single_txn("wr", 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 64'h0);
   endtask

   task automatic test_readback;
      single_txn("rd", 1'b0, 64'h10, 64'h0, 8'h0, 64'h1122334455667788);
   endtask

   task automatic test_byte_enables;
      single_txn("be_wr", 1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0);
      single_txn("be_rd", 1'b0, 64'h10, 64'h0, 8'h0, 64'h11223344FFFFFFFF);
   endtask

   task automatic test_outstanding;
      logic [6:0]  gnt_pat = 7'b0001011;
      logic [6:0]  rv_pat  = 7'b0101100;
      logic [63:0] addrs [4] = '{64'h0, 64'h8, 64'h10, 64'h10};
      logic [63:0] rds   [7] = '{64'h0, 64'h0, 64'hDEAD0000BEEF0001, 64'h0123456789ABCDEF,
                                 64'h0, 64'h11223344FFFFFFFF, 64'h0};
      single_txn("os_w0", 1'b1, 64'h0, 64'hDEAD0000BEEF0001, 8'hFF, 64'h0);
      single_txn("os_w8", 1'b1, 64'h8, 64'h0123456789ABCDEF, 8'hFF, 64'h0);
      for (int k = 0; k < 7; k++) begin
         do_cycle(k < 4, 1'b0, (k < 4) ? addrs[k] : 64'h0, 64'h0, 8'h0, 1'b0);
         n_checks++;
         if (obs_gnt !== gnt_pat[k]) begin n_fail++; $display("FAIL os_gnt k=%0d: got %b expected %b", k, obs_gnt, gnt_pat[k]); end
         n_checks++;
         if (obs_rv !== rv_pat[k]) begin n_fail++; $display("FAIL os_rvalid k=%0d: got %b expected %b", k, obs_rv, rv_pat[k]); end
         if (rv_pat[k]) begin
            n_checks++;
            if (obs_rd !== rds[k]) begin n_fail++; $display("FAIL os_rdata k=%0d: got %h expected %h", k, obs_rd, rds[k]); end
         end
      end
   endtask

   task automatic test_wrap;
      single_txn("wrap_wr", 1'b1, 64'h2000, 64'hA5, 8'hFF, 64'h0);
      single_txn("wrap_rd", 1'b0, 64'h0, 64'h0, 8'h0, 64'hA5);
   endtask

   task automatic test_reset_midflight;
      for (int k = 0; k < 5; k++) begin
         do_cycle(k == 0, 1'b0, 64'h0, 64'h0, 8'h0, k == 1);
         n_checks++;
         if (obs_gnt !== (k == 0)) begin n_fail++; $display("FAIL mid_gnt k=%0d: got %b expected %b", k, obs_gnt, k == 0); end
         n_checks++;
         if (obs_rv !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid k=%0d: got %b expected 0", k, obs_rv); end
         if (k >= 2) begin
            n_checks++;
            if (obs_rd !== 64'h0) begin n_fail++; $display("FAIL mid_rdata k=%0d: got %h expected 0", k, obs_rd); end
         end
      end
      single_txn("mid_after", 1'b0, 64'h0, 64'h0, 8'h0, 64'hA5);
   endtask

   task automatic test_random;
      logic        rq, w, r;
      logic [63:0] a, wd;
      logic [7:0]  b;
      int          budget;
      for (int wi = 0; wi < 16; wi++) begin
         wd = {$urandom, $urandom};
         budget = 0;
         do begin
            do_cycle(1'b1, 1'b1, 64'(wi * 8), wd, 8'hFF, 1'b0);
            budget++;
         end while (!obs_gnt && budget < 50);
         n_checks++;
         if (!obs_gnt) begin n_fail++; $display("FAIL rnd_prewrite_timeout word=%0d: got no grant expected grant", wi); end
      end
      rq = 1'b0; w = 1'b0; a = '0; wd = '0; b = '0;
      for (int k = 0; k < 500; k++) begin
         if (!rq || obs_gnt) begin
            rq = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1) == 1;
            a  = {$urandom, $urandom};
            a[12:7] = 6'b0;
            wd = {$urandom, $urandom};
            b  = 8'($urandom);
         end
         r = ($urandom_range(0, 99) == 0) && (k < 480);
         do_cycle(rq, w, a, wd, b, r);
         n_checks++;
         if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d: got %b expected %b", cyc, obs_gnt, exp_gnt); end
         n_checks++;
         if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d: got %b expected %b", cyc, obs_rv, exp_rv); end
         if (exp_rv) begin
            n_checks++;
            if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d: got %h expected %h", cyc, obs_rd, exp_rd); end
         end
         if (r) rq = 1'b0;
      end
      n_checks++;
      if (pend.size() > MAXO) begin n_fail++; $display("FAIL rnd_pending: got %0d expected <= %0d", pend.size(), MAXO); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
`ifndef MEM_RESPONDER_GNT_STALL_EN
      test_single_write();
      test_readback();
      test_byte_enables();
      test_outstanding();
      test_wrap();
      test_reset_midflight();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable slave-side responder for the core's generic memory request/grant/rvalid protocol.
- Accepts requests from an initiator (address, wdata, req, we, be) and drives data_gnt, data_rvalid and data_rdata.
- Backed by an internal word-addressed storage array, with a fixed-latency in-order response pipeline and a cap on outstanding requests.
- Used as the memory end in unit-level benches and in small FPGA/simulation subsystems.

Parameters:
- ADDRESS_SIZE, 64, width of the address bus.
- DATA_WIDTH, 64, data width in bits; must be a multiple of 8.
- NUM_WORDS, 1024, storage depth in DATA_WIDTH words; power of two.
- LATENCY, 2, cycles from the grant cycle to the rvalid cycle; range 1 to 8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; range 1 to LATENCY.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- address  input  ADDRESS_SIZE  byte address of the request.
- data_wdata  input  DATA_WIDTH  write data.
- data_req  input  1  request valid.
- data_we  input  1  1 = write, 0 = read.
- data_be  input  DATA_WIDTH/8  byte enables for writes.
- data_gnt  output  1  request accepted this cycle.
- data_rvalid  output  1  response valid.
- data_rdata  output  DATA_WIDTH  read data; 0 for write responses.

Behaviour:
- Reset and clocking: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Word index: address[OFF +: log2(NUM_WORDS)], where OFF = log2(DATA_WIDTH/8). Upper address bits and byte-offset bits are ignored, so out-of-range addresses wrap.
- Outstanding count: outstanding = number of valid entries in the response pipeline.
- Grant condition: data_gnt = data_req & ~rst_i & (outstanding < MAX_OUTSTANDING) & ~stall. stall is 0 unless the optional feature is enabled.
  - data_gnt is combinational from data_req.
- Initiator rule: after asserting data_req, the initiator holds all request fields stable until the grant. The responder does not check this.
- Granted write, in the grant cycle:
  - Each byte i with data_be[i] = 1 is written into the indexed word on the clock edge.
  - A response entry with rdata = 0 is pushed.
- Granted read:
  - The word is read in the grant cycle, before any write on that same edge. Only one request can be granted per cycle.
  - A response entry with that data is pushed.
- Response pipeline: LATENCY-stage shift register of {valid, data}, advancing every cycle with no backpressure.
  - data_rvalid and data_rdata are registered outputs of the last stage.
  - A request granted in cycle T gives data_rvalid = 1 in cycle T+LATENCY for exactly one cycle.
- Ordering: every grant produces exactly one rvalid, strictly in grant order.
- Outstanding accounting:
  - outstanding increments on a grant and decrements on an rvalid.
  - A simultaneous grant and rvalid leave it unchanged.
  - An rvalid in the same cycle frees a slot only from the next cycle, because the count is registered.
- Full condition: while outstanding == MAX_OUTSTANDING, data_gnt = 0 and the request waits.
- Back-to-back traffic: with LATENCY = MAX_OUTSTANDING = 1, one grant every other cycle. With MAX_OUTSTANDING = LATENCY ≥ 2, a grant every cycle is not sustainable. Sustained throughput is MAX_OUTSTANDING grants per LATENCY+1 cycles.
- Reset values: data_gnt = 0, data_rvalid = 0, data_rdata = 0, all pipeline valid bits = 0, outstanding = 0. Storage contents are not reset.
- Reset mid-operation: in-flight responses are discarded and no rvalid is issued for them. A write granted in the same cycle that rst_i rises is not performed, because the grant is suppressed.

Optional Feature:
- Macro: MEM_RESPONDER_GNT_STALL_EN.
- Enabled:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle.
  - stall = (lfsr[1:0] == 2'b00), giving roughly 25% grant suppression to exercise initiator wait handling.
  - Latency and ordering rules are unchanged.
- Disabled: stall = 0, no LFSR logic is present, and the grant depends only on req, reset and the outstanding count.

Test Plan:
- Reset then single write (LATENCY = 2): address 0x10, wdata 0x1122334455667788, be 0xFF, req 1 cycle.
  - Required: gnt in the same cycle, rvalid 2 cycles later with rdata = 0, outstanding returns to 0.
- Read-back: read 0x10.
  - Required: gnt, then rvalid at T+2 with rdata = 0x1122334455667788.
- Byte enables: write 0x10 with wdata 0xFFFFFFFFFFFFFFFF, be 0x0F, then read.
  - Required: rdata = 0x11223344FFFFFFFF.
- Outstanding limit (MAX_OUTSTANDING = 2): hold req high for reads at 0x0, 0x8, 0x10.
  - Required: gnt at T0 and T1, gnt low at T2, third grant only after outstanding drops.
  - Required: rvalid at T2 and T3, in order, with the three expected data values.
- Wrap-around (NUM_WORDS = 1024): write 0xA5 to address 0x2000, then read address 0x0.
  - Required: rdata = 0xA5.
- Reset mid-flight: grant a read at T, assert rst_i at T+1.
  - Required: no rvalid at T+2, outputs 0, first request after reset granted normally.
  - With MEM_RESPONDER_GNT_STALL_EN: same sequence completes with stalls and identical data and order.
